shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the single-cycle combinational SRL/SLL shifter in the ALU.
- Adds arithmetic right shift, rotates, a carry-out (last bit shifted out) and a zero flag.
- Uses a valid/ready handshake with full backpressure, so the execute stage can use it as a multi-cycle functional unit.
- A caller-supplied tag travels alongside each operation to identify it on the output.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, minimum 8.
- STAGES, 2, pipeline register stages (latency); legal range 1..$clog2(WIDTH).
- TAGW, 5, width of the opaque tag carried with each operation (e.g. destination register index).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  input operation valid.
- in_ready  out  1  shifter can accept an operation this cycle.
- in_a  in  WIDTH  operand.
- in_amt  in  $clog2(WIDTH)  shift amount, unsigned.
- in_mode  in  3  operation, encoding from the package.
- in_tag  in  TAGW  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  WIDTH  shifted result.
- out_carry  out  1  last bit shifted out.
- out_zero  out  1  out_res == 0.
- out_tag  out  TAGW  tag of the operation in the output slot.

Behaviour:
- Modes:
  - SRL=0: logical right.
  - SLL=1: logical left.
  - SRA=2: arithmetic right, sign bit in_a[WIDTH-1] replicated.
  - ROR=3: rotate right.
  - ROL=4: rotate left.
  - Codes 5..7 are reserved: result = in_a, carry = 0.
- Structure:
  - log2(WIDTH) shift levels; level i shifts by 2^i when in_amt[i] is set.
  - Level i is placed in stage floor(i*STAGES/log2(WIDTH)).
  - A register bank follows each stage and holds valid, partial result, remaining amt bits, mode, carry and tag.
- Carry:
  - Computed from the input operand in stage 0.
  - Right modes: carry = in_a[amt-1].
  - Left modes: carry = in_a[WIDTH-amt].
  - amt == 0: carry = 0 for all modes.
- Zero flag: computed combinationally from the final stage register.
- Latency:
  - An operation accepted in cycle N appears on out_* in cycle N+STAGES, provided there is no stall.
  - Throughput is 1 operation per cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - adv = !out_valid || out_ready.
  - All stages advance together when adv = 1; in_ready = adv.
  - When adv = 0 every stage holds and out_* stays stable until accepted.
  - There are no combinational paths from in_* to out_*.
  - in_ready depends only on out_valid and out_ready.
  - A bubble (in_valid = 0 while adv = 1) enters stage 0 with valid = 0.
- flush:
  - All stage valid bits clear on the next edge; data registers are don't-care.
  - flush overrides a simultaneous accept: the operation presented that cycle is dropped.
  - in_ready is unaffected by flush.
- Reset (rst_n low, asynchronous):
  - All valid bits, out_res, out_carry and out_tag go to 0.
  - out_zero therefore reads 1 but is meaningless while out_valid = 0.
  - An operation in flight when reset asserts is lost.
  - After release the pipeline is empty and in_ready = 1.
- Back-to-back accepts, stalls mid-flight and a stall coinciding with a bubble must not duplicate or drop any accepted operation.

Decomposition:
- Package shift_pkg holds:
  - the mode localparams (SRL, SLL, SRA, ROR, ROL);
  - a function computing the stage index of level i.
- Natural sub-module: shift_level, a combinational single level. Inputs: data, enable, mode, fill bit. Parameter: distance. Instantiated log2(WIDTH) times via generate.

Test Plan (WIDTH=32, STAGES=2):
- Basic modes, with out_ready = 1:
  - in_a=0x8000_00F1, amt=4.
  - SRL -> 0x0800_000F, carry=0.
  - SRA -> 0xF800_000F, carry=0.
  - ROR -> 0x1800_000F, carry=0.
  - Each result appears exactly 2 cycles after accept.
- Left shifts and boundaries, in_a=0xC000_0001:
  - SLL amt=1 -> 0x8000_0002, carry=1.
  - ROL amt=31 -> 0xE000_0000, carry=0.
  - amt=0 in any mode -> 0xC000_0001, carry=0.
  - SLL in_a=0x8000_0000 amt=1 -> res=0, out_zero=1, carry=1.
- Backpressure:
  - Stream 6 ops with tags 1..6 while out_ready toggles 1,0,0,1,...
  - Outputs arrive in tag order 1..6 with no duplicates or losses.
  - out_* stays stable during stalls.
  - in_ready=0 exactly when out_valid=1 && out_ready=0.
- Flush:
  - Accept 2 ops, assert flush in the cycle a third op is accepted.
  - No out_valid follows.
  - The next op is accepted the following cycle and emerges normally.
- Reset mid-flight:
  - Pull rst_n low asynchronously between edges with 2 ops in flight.
  - out_valid drops immediately.
  - After release, in_ready=1 and no stale result emerges.
- Parameter sweep:
  - Run randomized ops against a reference model for STAGES=1 and STAGES=5, with WIDTH=32 and WIDTH=64.
  - Random out_ready; all results, carries and tags must match.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation codes and
// the mapping of shift levels onto pipeline stages.
package shift_pkg;

   localparam logic [2:0] SRL = 3'd0;
   localparam logic [2:0] SLL = 3'd1;
   localparam logic [2:0] SRA = 3'd2;
   localparam logic [2:0] ROR = 3'd3;
   localparam logic [2:0] ROL = 3'd4;

   // Stage that hosts shift level 'level' when 'levels' levels share 'stages' stages.
   function automatic int level_stage(input int level, input int stages, input int levels);
      return (level * stages) / levels;
   endfunction

endpackage

// File: rtl/shift_pipe_level.sv
// One combinational shift level: moves data by DIST bit positions in the
// direction selected by mode, or passes it through when disabled.
module shift_pipe_level
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             fill,
   output logic [WIDTH-1:0] res
);

   // Select the shifted or rotated form of the input; fill supplies the SRA sign.
   always_comb begin
      res = data;
      if (en) begin
         case (mode)
            SRL:     res = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
            SRA:     res = {{DIST{fill}}, data[WIDTH-1:DIST]};
            ROR:     res = {data[DIST-1:0], data[WIDTH-1:DIST]};
            SLL:     res = {data[WIDTH-1-DIST:0], {DIST{1'b0}}};
            ROL:     res = {data[WIDTH-1-DIST:0], data[WIDTH-1:WIDTH-DIST]};
            default: res = data;
         endcase
      end else begin
         res = data;
      end
   end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) shift levels spread over STAGES
// register banks, with valid/ready backpressure and a tag per operation.
module shift_pipe
   import shift_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAGW   = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [$clog2(WIDTH)-1:0] in_amt,
   input  logic [2:0]               in_mode,
   input  logic [TAGW-1:0]          in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_res,
   output logic                     out_carry,
   output logic                     out_zero,
   output logic [TAGW-1:0]          out_tag
);

   localparam int LEVELS = $clog2(WIDTH);

   logic                  adv_s;
   logic                  carry_s;
   logic [LEVELS-1:0]     cidx_s;

   logic [STAGES-1:0]     valid_r;
   logic [WIDTH-1:0]      data_r  [STAGES];
   logic [LEVELS-1:0]     amt_r   [STAGES];
   logic [2:0]            mode_r  [STAGES];
   logic                  fill_r  [STAGES];
   logic                  carry_r [STAGES];
   logic [TAGW-1:0]       tag_r   [STAGES];

   logic [WIDTH-1:0]      st_data_s [STAGES];
   logic [LEVELS-1:0]     st_amt_s  [STAGES];
   logic [2:0]            st_mode_s [STAGES];
   logic                  st_fill_s [STAGES];
   logic [WIDTH-1:0]      st_out_s  [STAGES];
   logic [WIDTH-1:0]      lvl_out_s [LEVELS];

   assign adv_s    = !valid_r[STAGES-1] || out_ready;
   assign in_ready = adv_s;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage_in
      if (s == 0) begin : g_head
         assign st_data_s[s] = in_a;
         assign st_amt_s[s]  = in_amt;
         assign st_mode_s[s] = in_mode;
         assign st_fill_s[s] = in_a[WIDTH-1];
      end else begin : g_body
         assign st_data_s[s] = data_r[s-1];
         assign st_amt_s[s]  = amt_r[s-1];
         assign st_mode_s[s] = mode_r[s-1];
         assign st_fill_s[s] = fill_r[s-1];
      end
   end

   // Levels of one stage chain combinationally; the last one feeds that stage's bank.
   for (genvar i = 0; i < LEVELS; i++) begin : g_level
      localparam int S = level_stage(i, STAGES, LEVELS);
      logic [WIDTH-1:0] lvl_in_s;

      if (i == 0 || level_stage(i - 1, STAGES, LEVELS) != S) begin : g_first
         assign lvl_in_s = st_data_s[S];
      end else begin : g_chain
         assign lvl_in_s = lvl_out_s[i-1];
      end

      shift_pipe_level #(.WIDTH(WIDTH), .DIST(1 << i)) u_level (
         .data (lvl_in_s),
         .en   (st_amt_s[S][i]),
         .mode (st_mode_s[S]),
         .fill (st_fill_s[S]),
         .res  (lvl_out_s[i])
      );

      if (i == LEVELS - 1 || level_stage(i + 1, STAGES, LEVELS) != S) begin : g_last
         assign st_out_s[S] = lvl_out_s[i];
      end
   end

   // Carry is the last bit shifted out; WIDTH-amt wraps naturally in LEVELS bits.
   always_comb begin
      carry_s = 1'b0;
      cidx_s  = {LEVELS{1'b0}};
      if (in_amt == {LEVELS{1'b0}}) begin
         carry_s = 1'b0;
      end else begin
         case (in_mode)
            SRL, SRA, ROR: begin
               cidx_s  = in_amt - LEVELS'(1);
               carry_s = in_a[cidx_s];
            end
            SLL, ROL: begin
               cidx_s  = {LEVELS{1'b0}} - in_amt;
               carry_s = in_a[cidx_s];
            end
            default: carry_s = 1'b0;
         endcase
      end
   end

   // Register banks: all stages advance together; flush only kills the valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {STAGES{1'b0}};
         for (int s = 0; s < STAGES; s++) begin
            data_r[s]  <= {WIDTH{1'b0}};
            amt_r[s]   <= {LEVELS{1'b0}};
            mode_r[s]  <= 3'd0;
            fill_r[s]  <= 1'b0;
            carry_r[s] <= 1'b0;
            tag_r[s]   <= {TAGW{1'b0}};
         end
      end else begin
         if (adv_s) begin
            for (int s = 0; s < STAGES; s++) begin
               data_r[s] <= st_out_s[s];
               amt_r[s]  <= st_amt_s[s];
               mode_r[s] <= st_mode_s[s];
               fill_r[s] <= st_fill_s[s];
            end
            carry_r[0] <= carry_s;
            tag_r[0]   <= in_tag;
            for (int s = 1; s < STAGES; s++) begin
               carry_r[s] <= carry_r[s-1];
               tag_r[s]   <= tag_r[s-1];
            end
         end
         if (flush) begin
            valid_r <= {STAGES{1'b0}};
         end else if (adv_s) begin
            valid_r[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) begin
               valid_r[s] <= valid_r[s-1];
            end
         end
      end
   end

   assign out_valid = valid_r[STAGES-1];
   assign out_res   = data_r[STAGES-1];
   assign out_carry = carry_r[STAGES-1];
   assign out_tag   = tag_r[STAGES-1];
   assign out_zero  = (data_r[STAGES-1] == {WIDTH{1'b0}});

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed mode/boundary/handshake tests on a
// 32-bit 2-stage instance, then randomized sweeps over four width/stage configurations.
`timescale 1ns/1ps
module tb_shift_pipe;
   import shift_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic sweep_go = 1'b0;

   logic        m_flush, m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_carry, m_out_zero;
   logic [31:0] m_in_a, m_out_res;
   logic [4:0]  m_in_amt, m_in_tag, m_out_tag;
   logic [2:0]  m_in_mode;

   shift_pipe #(.WIDTH(32), .STAGES(2), .TAGW(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(m_flush),
      .in_valid(m_in_valid), .in_ready(m_in_ready), .in_a(m_in_a), .in_amt(m_in_amt),
      .in_mode(m_in_mode), .in_tag(m_in_tag),
      .out_valid(m_out_valid), .out_ready(m_out_ready), .out_res(m_out_res),
      .out_carry(m_out_carry), .out_zero(m_out_zero), .out_tag(m_out_tag)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: {carry, result} of one operation on a w-bit operand, plain arithmetic.
   function automatic logic [64:0] ref_op(input int w, input logic [63:0] a, input int amt,
                                          input logic [2:0] mode);
      logic [63:0] mask;
      logic [63:0] r;
      logic        c;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      case (mode)
         SRL:     r = a >> amt;
         SLL:     r = (a << amt) & mask;
         SRA:     r = a[w-1] ? ((a >> amt) | (mask & ~(mask >> amt))) : (a >> amt);
         ROR:     r = ((a >> amt) | (a << (w - amt))) & mask;
         ROL:     r = ((a << amt) | (a >> (w - amt))) & mask;
         default: r = a;
      endcase
      if (amt == 0)                                   c = 1'b0;
      else if (mode == SRL || mode == SRA || mode == ROR) c = a[amt-1];
      else if (mode == SLL || mode == ROL)            c = a[w-amt];
      else                                            c = 1'b0;
      return {c, r};
   endfunction

   task automatic do_op(input string name, input logic [2:0] mode, input logic [31:0] a,
                        input logic [4:0] amt, input logic [31:0] er, input logic ec);
      logic [4:0] tg;
      tg = 5'($urandom);
      @(negedge clk);
      m_in_valid = 1'b1; m_in_a = a; m_in_amt = amt; m_in_mode = mode; m_in_tag = tg;
      m_out_ready = 1'b1;
      #1 check_eq({name, ".acc"}, 64'(m_in_ready), 64'd1);
      @(negedge clk);
      m_in_valid = 1'b0;
      #1 check_eq({name, ".lat1"}, 64'(m_out_valid), 64'd0);
      @(negedge clk);
      #1;
      check_eq({name, ".valid"}, 64'(m_out_valid), 64'd1);
      check_eq({name, ".res"},   64'(m_out_res),   64'(er));
      check_eq({name, ".carry"}, 64'(m_out_carry), 64'(ec));
      check_eq({name, ".tag"},   64'(m_out_tag),   64'(tg));
      check_eq({name, ".zero"},  64'(m_out_zero),  64'(er == 32'd0));
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_sweep
      localparam int W   = (g < 2) ? 32 : 64;
      localparam int S   = (g % 2 == 1) ? 5 : 1;
      localparam int AWL = $clog2(W);
      logic           in_valid, in_ready, flush, out_valid, out_ready, out_carry, out_zero, done;
      logic [W-1:0]   in_a, out_res;
      logic [AWL-1:0] in_amt;
      logic [2:0]     in_mode;
      logic [4:0]     in_tag, out_tag;

      shift_pipe #(.WIDTH(W), .STAGES(S), .TAGW(5)) u_dut (
         .clk(clk), .rst_n(rst_n), .flush(flush),
         .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_amt(in_amt),
         .in_mode(in_mode), .in_tag(in_tag),
         .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
         .out_carry(out_carry), .out_zero(out_zero), .out_tag(out_tag)
      );

      initial begin : run
         logic [69:0] q[$];
         logic [69:0] e;
         logic [64:0] r;
         logic        pstall, pflush, pcar;
         logic [W-1:0] pres;
         logic [4:0]  ptag;
         string       nm;
         nm = $sformatf("sw_w%0d_s%0d", W, S);
         done = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
         in_a = {W{1'b0}}; in_amt = {AWL{1'b0}}; in_mode = 3'd0; in_tag = 5'd0;
         pstall = 1'b0; pflush = 1'b0; pcar = 1'b0; pres = {W{1'b0}}; ptag = 5'd0;
         wait (sweep_go);
         for (int c = 0; c < 360; c++) begin
            @(negedge clk);
            if (c < 340) begin
               in_valid  = ($urandom_range(0, 3) != 0);
               in_a      = W'({$urandom(), $urandom()});
               in_amt    = AWL'($urandom());
               in_mode   = 3'($urandom_range(0, 7));
               in_tag    = 5'($urandom());
               out_ready = ($urandom_range(0, 2) != 0);
               flush     = ($urandom_range(0, 31) == 0);
            end else begin
               in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
            end
            #1;
            check_eq({nm, ".rdy"}, 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (pstall && !pflush) begin
               check_eq({nm, ".hold_v"}, 64'(out_valid), 64'd1);
               check_eq({nm, ".hold_r"}, 64'(out_res),   64'(pres));
               check_eq({nm, ".hold_t"}, 64'(out_tag),   64'(ptag));
               check_eq({nm, ".hold_c"}, 64'(out_carry), 64'(pcar));
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  check_eq({nm, ".spurious"}, 64'(out_valid), 64'd0);
               end else begin
                  e = q.pop_front();
                  check_eq({nm, ".res"},   64'(out_res),   e[63:0]);
                  check_eq({nm, ".carry"}, 64'(out_carry), 64'(e[64]));
                  check_eq({nm, ".tag"},   64'(out_tag),   64'(e[69:65]));
                  check_eq({nm, ".zero"},  64'(out_zero),  64'(e[63:0] == 64'd0));
               end
            end
            if (flush) begin
               q.delete();
            end else if (in_valid && in_ready) begin
               r = ref_op(W, 64'(in_a), int'(in_amt), in_mode);
               q.push_back({in_tag, r});
            end
            pstall = out_valid && !out_ready;
            pflush = flush;
            pres = out_res; ptag = out_tag; pcar = out_carry;
         end
         check_eq({nm, ".drain"}, 64'(q.size()), 64'd0);
         done = 1'b1;
      end
   end

   initial begin : main
      logic [37:0] bq[$];
      logic [37:0] e;
      logic [64:0] r;
      int          sent, rcvd;
      logic        pstall, pcar;
      logic [31:0] pres;
      logic [4:0]  ptag;

      rst_n = 1'b0; m_flush = 1'b0; m_in_valid = 1'b0; m_out_ready = 1'b1;
      m_in_a = 32'd0; m_in_amt = 5'd0; m_in_mode = 3'd0; m_in_tag = 5'd0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst.valid", 64'(m_out_valid), 64'd0);
      check_eq("rst.res",   64'(m_out_res),   64'd0);
      check_eq("rst.carry", 64'(m_out_carry), 64'd0);
      check_eq("rst.tag",   64'(m_out_tag),   64'd0);
      check_eq("rst.zero",  64'(m_out_zero),  64'd1);
      check_eq("rst.ready", 64'(m_in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("srl",     SRL, 32'h8000_00F1, 5'd4,  32'h0800_000F, 1'b0);
      do_op("sra",     SRA, 32'h8000_00F1, 5'd4,  32'hF800_000F, 1'b0);
      do_op("ror",     ROR, 32'h8000_00F1, 5'd4,  32'h1800_000F, 1'b0);
      do_op("sll1",    SLL, 32'hC000_0001, 5'd1,  32'h8000_0002, 1'b1);
      do_op("rol31",   ROL, 32'hC000_0001, 5'd31, 32'hE000_0000, 1'b0);
      do_op("sra0",    SRA, 32'hC000_0001, 5'd0,  32'hC000_0001, 1'b0);
      do_op("rol0",    ROL, 32'hC000_0001, 5'd0,  32'hC000_0001, 1'b0);
      do_op("sllzero", SLL, 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1);
      do_op("rsvd",    3'd5, 32'h1234_5678, 5'd7, 32'h1234_5678, 1'b0);

      // Backpressure: six tagged ops while out_ready runs 1,0,0,1,0,0,...
      sent = 1; rcvd = 0; pstall = 1'b0; pres = 32'd0; ptag = 5'd0; pcar = 1'b0;
      for (int c = 0; c < 60 && rcvd < 6; c++) begin
         @(negedge clk);
         m_out_ready = (c % 3 == 0);
         m_in_valid  = (sent <= 6);
         m_in_a      = $urandom();
         m_in_amt    = 5'($urandom());
         m_in_mode   = 3'($urandom_range(0, 4));
         m_in_tag    = 5'(sent);
         #1;
         check_eq("bp.rdy", 64'(m_in_ready), 64'(!(m_out_valid && !m_out_ready)));
         if (pstall) begin
            check_eq("bp.hold_v", 64'(m_out_valid), 64'd1);
            check_eq("bp.hold_r", 64'(m_out_res),   64'(pres));
            check_eq("bp.hold_t", 64'(m_out_tag),   64'(ptag));
            check_eq("bp.hold_c", 64'(m_out_carry), 64'(pcar));
         end
         if (m_out_valid && m_out_ready) begin
            if (bq.size() == 0) begin
               check_eq("bp.spurious", 64'(m_out_valid), 64'd0);
            end else begin
               e = bq.pop_front();
               check_eq("bp.tag",   64'(m_out_tag),   64'(e[37:33]));
               check_eq("bp.res",   64'(m_out_res),   64'(e[31:0]));
               check_eq("bp.carry", 64'(m_out_carry), 64'(e[32]));
               rcvd++;
            end
         end
         if (m_in_valid && m_in_ready) begin
            r = ref_op(32, 64'(m_in_a), int'(m_in_amt), m_in_mode);
            bq.push_back({5'(sent), r[64], r[31:0]});
            sent++;
         end
         pstall = m_out_valid && !m_out_ready;
         pres = m_out_res; ptag = m_out_tag; pcar = m_out_carry;
      end
      check_eq("bp.count", 64'(rcvd), 64'd6);

      // Flush on the cycle a third op is accepted; the op after it must emerge.
      @(negedge clk);
      m_out_ready = 1'b1; m_in_valid = 1'b1; m_in_mode = SRL; m_in_a = 32'hFF00; m_in_amt = 5'd8;
      m_in_tag = 5'd11;
      @(negedge clk);
      m_in_tag = 5'd12;
      @(negedge clk);
      m_in_tag = 5'd13; m_flush = 1'b1;
      #1 check_eq("fl.ready", 64'(m_in_ready), 64'd1);
      @(negedge clk);
      m_flush = 1'b0; m_in_tag = 5'd14; m_in_a = 32'h0000_0300; m_in_amt = 5'd8;
      #1;
      check_eq("fl.kill1", 64'(m_out_valid), 64'd0);
      check_eq("fl.acc",   64'(m_in_ready),  64'd1);
      @(negedge clk);
      m_in_valid = 1'b0;
      #1 check_eq("fl.kill2", 64'(m_out_valid), 64'd0);
      @(negedge clk);
      #1;
      check_eq("fl.valid", 64'(m_out_valid), 64'd1);
      check_eq("fl.tag",   64'(m_out_tag),   64'd14);
      check_eq("fl.res",   64'(m_out_res),   64'd3);
      @(negedge clk);
      #1 check_eq("fl.after", 64'(m_out_valid), 64'd0);

      // Asynchronous reset with two ops in flight.
      @(negedge clk);
      m_in_valid = 1'b1; m_in_tag = 5'd21; m_in_a = 32'h1;
      @(negedge clk);
      m_in_tag = 5'd22;
      @(negedge clk);
      m_in_valid = 1'b0;
      #1 check_eq("rm.pre", 64'(m_out_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("rm.valid", 64'(m_out_valid), 64'd0);
      check_eq("rm.tag",   64'(m_out_tag),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_eq("rm.ready", 64'(m_in_ready), 64'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1 check_eq("rm.stale", 64'(m_out_valid), 64'd0);
      end

      sweep_go = 1'b1;
      for (int t = 0; t < 2000; t++) begin
         if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done) break;
         @(negedge clk);
      end
      check_eq("sweep.done",
               64'({g_sweep[3].done, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}),
               64'hF);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
